// File: rtl/shftreg_ctrl_if.sv
// shftreg_ctrl_if: command handshake between a host front end and the shift-register sequencer.
// Carries tx_rot only when SHFTREG_CTRL_ROT_EN is defined.
interface shftreg_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_dir;
    logic [CNT_W-1:0] tx_count;
    logic             tx_abort;
`ifdef SHFTREG_CTRL_ROT_EN
    logic             tx_rot;
    modport slave  (input  tx_valid, tx_data, tx_dir, tx_count, tx_abort, tx_rot, output tx_ready);
    modport master (output tx_valid, tx_data, tx_dir, tx_count, tx_abort, tx_rot, input  tx_ready);
`else
    modport slave  (input  tx_valid, tx_data, tx_dir, tx_count, tx_abort, output tx_ready);
    modport master (output tx_valid, tx_data, tx_dir, tx_count, tx_abort, input  tx_ready);
`endif
endinterface

// File: rtl/shftreg_ctrl.sv
// shftreg_ctrl: load/shift sequencer for a negedge-clocked shift register with parallel load.
// Define SHFTREG_CTRL_ROT_EN to add rotate mode (tx_rot) where the outgoing bit refills the register.
module shftreg_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             Clear,
    shftreg_ctrl_if.slave    tx,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_ld,
    output logic             sr_rl,
    output logic             sr_ins,
    output logic             sr_clear_n,
    output logic [WIDTH-1:0] sr_par,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = (CNT_W > $clog2(WIDTH + 1)) ? CNT_W : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [CW-1:0]    cnt;
`ifdef SHFTREG_CTRL_ROT_EN
    logic             rot;
`endif

    always_comb begin
        nxt = state == IDLE  ? (tx.tx_valid ? LOAD : IDLE) :
              state == LOAD  ? (tx.tx_abort ? IDLE : SHIFT) :
              state == SHIFT ? (tx.tx_abort ? IDLE : cnt == CW'(1) ? DONE : SHIFT) :
                               IDLE;
    end

    // Outputs are registered from the next state so they are stable a half cycle before the negedge.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state         <= IDLE;
            data          <= '0;
            dir           <= 1'b0;
            cnt           <= '0;
`ifdef SHFTREG_CTRL_ROT_EN
            rot           <= 1'b0;
`endif
            tx.tx_ready   <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            sr_ld         <= 1'b1;
            sr_rl         <= 1'b0;
            ser_out_valid <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && tx.tx_valid) begin
                data <= tx.tx_data;
                dir  <= tx.tx_dir;
                cnt  <= (tx.tx_count == '0) ? CW'(WIDTH) : CW'(tx.tx_count);
`ifdef SHFTREG_CTRL_ROT_EN
                rot  <= tx.tx_rot;
`endif
            end else if (state == SHIFT) begin
                cnt <= cnt - CW'(1);
            end
            tx.tx_ready   <= nxt == IDLE;
            busy          <= nxt != IDLE;
            done          <= nxt == DONE;
            sr_ld         <= nxt != SHIFT;
            sr_rl         <= nxt == LOAD ? tx.tx_dir : (nxt == SHIFT) & dir;
            ser_out_valid <= nxt == SHIFT;
        end
    end

    // Every non-LOAD cycle with sr_ld high recirculates sr_q so the register holds.
    assign sr_par     = state == LOAD ? data : sr_q;
    assign sr_clear_n = ~Clear;
    assign ser_out    = ser_out_valid & (dir ? sr_q[WIDTH-1] : sr_q[0]);
`ifdef SHFTREG_CTRL_ROT_EN
    assign sr_ins     = ser_out_valid & (rot ? ser_out : ser_in);
`else
    assign sr_ins     = ser_out_valid & ser_in;
`endif
endmodule

// File: tb/tb_shftreg_ctrl.sv
// tb_shftreg_ctrl: directed scoreboard bench for shftreg_ctrl with a behavioural negedge shift register.
module tb_shftreg_ctrl;
    localparam int W = 4;
    localparam int C = 3;

    logic         clk = 1'b0;
    logic         clear = 1'b1;
    logic         ser_in = 1'b0;
    logic [W-1:0] q = 4'b1010;
    logic         sr_ld, sr_rl, sr_ins, sr_clear_n, ser_out, ser_out_valid, busy, done;
    logic [W-1:0] sr_par;

    int   checks = 0;
    int   errors = 0;
    logic exp_bits[$];
    int   exp_done[$];

    shftreg_ctrl_if #(.WIDTH(W), .CNT_W(C)) tx ();

    shftreg_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .CLK(clk), .Clear(clear), .tx(tx), .ser_in(ser_in), .sr_q(q),
        .sr_ld(sr_ld), .sr_rl(sr_rl), .sr_ins(sr_ins), .sr_clear_n(sr_clear_n),
        .sr_par(sr_par), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Shift register model: active-low clear, parallel load, RL=1 shifts toward the MSB.
    always @(negedge clk) begin
        if (!sr_clear_n) q <= '0;
        else if (sr_ld) q <= sr_par;
        else if (sr_rl) q <= {q[W-2:0], sr_ins};
        else q <= {sr_ins, q[W-1:1]};
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (ser_out_valid === 1'b1) begin
            if (exp_bits.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ser_out_unexpected actual=%b expected=none at %0t", ser_out, $time);
            end else chk("ser_out", {3'b0, ser_out}, {3'b0, exp_bits.pop_front()});
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected actual=1 expected=0 at %0t", $time);
            end else void'(exp_done.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_bits(input logic [7:0] v, input int n, input bit with_done);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
        if (with_done) exp_done.push_back(1);
    endtask

    task automatic send(input logic [W-1:0] d, input logic dir, input logic [C-1:0] cnt,
                        input logic rot, input logic si);
        logic rdy;
        bit   acc;
        acc = 0;
        tx.tx_data  = d;
        tx.tx_dir   = dir;
        tx.tx_count = cnt;
`ifdef SHFTREG_CTRL_ROT_EN
        tx.tx_rot   = rot;
`endif
        ser_in      = si;
        tx.tx_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            rdy = tx.tx_ready;
            tick(1);
            acc = rdy;
        end
        tx.tx_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=0 expected=1 (tx_ready never seen)");
        end
    endtask

    initial begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = '0;
        tx.tx_dir   = 1'b0;
        tx.tx_count = '0;
        tx.tx_abort = 1'b0;
`ifdef SHFTREG_CTRL_ROT_EN
        tx.tx_rot   = 1'b0;
`endif
        tick(1);
        chk("rst_clear_n", {3'b0, sr_clear_n}, 4'd0);
        chk("rst_ready", {3'b0, tx.tx_ready}, 4'd1);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_done", {3'b0, done}, 4'd0);
        chk("rst_ld", {3'b0, sr_ld}, 4'd1);
        chk("rst_valid", {3'b0, ser_out_valid}, 4'd0);
        tick(1);
        chk("rst_clear_n2", {3'b0, sr_clear_n}, 4'd0);
        chk("rst_q", q, 4'b0000);
        clear = 1'b0;
        tick(1);
        chk("clear_n_high", {3'b0, sr_clear_n}, 4'd1);

        expect_bits(8'b1101, 4, 1);
        send(4'b1011, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("t2_ready_low", {3'b0, tx.tx_ready}, 4'd0);
        chk("t2_load_par", sr_par, 4'b1011);
        tick(5);
        chk("t2_done", {3'b0, done}, 4'd1);
        chk("t2_q", q, 4'b0000);
        tick(1);
        chk("t2_ready", {3'b0, tx.tx_ready}, 4'd1);
        chk("t2_done_low", {3'b0, done}, 4'd0);

        expect_bits(8'b01, 2, 1);
        send(4'b0110, 1'b1, 3'd2, 1'b0, 1'b1);
        tick(3);
        chk("t3_done", {3'b0, done}, 4'd1);
        chk("t3_q", q, 4'b1011);
        tick(5);
        chk("t3_hold_q", q, 4'b1011);
        chk("t3_hold_par", sr_par, 4'b1011);

        expect_bits(8'b11, 2, 0);
        send(4'b1111, 1'b0, 3'd4, 1'b0, 1'b0);
        tick(2);
        tx.tx_abort = 1'b1;
        tick(1);
        tx.tx_abort = 1'b0;
        chk("t4_ready", {3'b0, tx.tx_ready}, 4'd1);
        chk("t4_busy", {3'b0, busy}, 4'd0);
        chk("t4_q", q, 4'b0011);
        tick(3);
        chk("t4_hold_q", q, 4'b0011);

        expect_bits(8'b001, 3, 1);
        send(4'b1100, 1'b0, 3'd3, 1'b0, 1'b0);
        tx.tx_valid = 1'b1;
        tx.tx_data  = 4'b0101;
        tx.tx_count = 3'd0;
        tick(4);
        chk("t5_done", {3'b0, done}, 4'd1);
        chk("t5_ready_low", {3'b0, tx.tx_ready}, 4'd0);
        chk("t5_q", q, 4'b0001);
        expect_bits(8'b10, 2, 0);
        send(4'b0101, 1'b0, 3'd0, 1'b0, 1'b0);
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("t5_clr_ready", {3'b0, tx.tx_ready}, 4'd1);
        chk("t5_clr_busy", {3'b0, busy}, 4'd0);
        chk("t5_clr_q", q, 4'b0000);
        tick(3);

`ifdef SHFTREG_CTRL_ROT_EN
        expect_bits(8'b1, 1, 1);
        send(4'b1001, 1'b1, 3'd1, 1'b1, 1'b0);
        tick(2);
        chk("t6_done", {3'b0, done}, 4'd1);
        chk("t6_q", q, 4'b0011);
        tick(1);
        expect_bits(8'b1001, 4, 1);
        send(4'b1001, 1'b1, 3'd0, 1'b1, 1'b0);
        tick(5);
        chk("t6_rot_done", {3'b0, done}, 4'd1);
        chk("t6_rot_q", q, 4'b1001);
`endif
        tick(2);
        chk("sb_empty", 4'(exp_bits.size() + exp_done.size()), 4'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
